pu_da_inv_ctrl: RTL and testbench

Invalidation initiator for the data-cache tag/valid array's second (invalidate) port. It accepts physical-address invalidate requests from the coherence/snoop logic and reads the tag/valid at the line's index. On a valid tag match it writes valid=0 and reports hit/miss. It watches the memory port for same-index writes and retries to avoid read/write collisions.

---
 rtl/pu_da_inv_ctrl_pkg.sv | 29 ++
 rtl/pu_da_inv_ctrl_if.sv | 22 ++
 rtl/pu_da_inv_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pu_da_inv_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_da_inv_ctrl_pkg.sv
// Shared widths, FSM state encodings and address-split helpers for the
// data-cache invalidate-port controller.
package pu_da_inv_ctrl_pkg;

    localparam int INDEX_W  = 7;   // 128 lines
    localparam int TAG_W    = 20;  // physical tag
    localparam int OFFSET_W = 5;   // 32-byte (256-bit) line
    localparam int PA_W     = TAG_W + INDEX_W + OFFSET_W;

    // FSM encodings kept as plain constants so older tools can consume them.
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_RD    = 2'd1;
    localparam logic [STATE_W-1:0] ST_CMP   = 2'd2;
    localparam logic [STATE_W-1:0] ST_FLUSH = 2'd3;

    localparam logic [INDEX_W-1:0] LAST_INDEX = '1;

    // Tag field of a physical address.
    function automatic logic [TAG_W-1:0] pa_tag(input logic [PA_W-1:0] addr);
        return addr[PA_W-1:PA_W-TAG_W];
    endfunction

    // Line index of a physical address; the byte offset is irrelevant here.
    function automatic logic [INDEX_W-1:0] pa_index(input logic [PA_W-1:0] addr);
        return addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    endfunction

endpackage

// File: rtl/pu_da_inv_ctrl_if.sv
// Invalidate request / completion channel between the snoop logic (master)
// and the invalidate controller (slave).
interface pu_da_inv_ctrl_if;
    import pu_da_inv_ctrl_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [PA_W-1:0] req_addr;
    logic            done_valid;
    logic            done_hit;

    modport master (
        output req_valid, req_addr,
        input  req_ready, done_valid, done_hit
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, done_valid, done_hit
    );

endinterface

// File: rtl/pu_da_inv_ctrl.sv
// Data-cache invalidate-port controller: reads tag/valid at the request's
// index, clears the valid bit on a tag match and reports hit/miss. Backs off
// whenever the memory port writes the same index.
// Optional whole-array flush is built when PU_DC_INV_FLUSH_EN is defined.
module pu_da_inv_ctrl
    import pu_da_inv_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    pu_da_inv_ctrl_if.slave    bus,
    input  logic               mem_wr_en,
    input  logic [INDEX_W-1:0] mem_rw_index,
    output logic [INDEX_W-1:0] inv_rw_index,
    output logic               inv_wr_en,
    output logic [TAG_W-1:0]   inv_wr_ptag,
    output logic               inv_wr_valid,
    input  logic [TAG_W-1:0]   inv_rd_ptag,
    input  logic               inv_rd_valid
`ifdef PU_DC_INV_FLUSH_EN
    ,
    input  logic               flush_req,
    output logic               flush_done
`endif
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic               done_valid_q, done_valid_d;
    logic               done_hit_q, done_hit_d;
`ifdef PU_DC_INV_FLUSH_EN
    logic [INDEX_W-1:0] flush_cnt_q, flush_cnt_d;
    logic               flush_done_q, flush_done_d;
`endif

    logic [INDEX_W-1:0] cur_index;
    logic               collide;
    logic               hit;
    logic               wr_en_c;
    logic [TAG_W-1:0]   wr_ptag_c;

    // The byte offset is deliberately ignored.
    wire unused_offset = ^bus.req_addr[OFFSET_W-1:0];

    // Array index in use this cycle, memory-port collision and tag compare.
    always_comb begin
        cur_index = index_q;
`ifdef PU_DC_INV_FLUSH_EN
        if (state_q == ST_FLUSH) cur_index = flush_cnt_q;
`endif
        collide = mem_wr_en && (mem_rw_index == cur_index);
        hit     = inv_rd_valid && (inv_rd_ptag == tag_q);
    end

    // Next-state and register-input logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        tag_d        = tag_q;
        index_d      = index_q;
        done_valid_d = 1'b0;
        done_hit_d   = 1'b0;
`ifdef PU_DC_INV_FLUSH_EN
        flush_cnt_d  = flush_cnt_q;
        flush_done_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef PU_DC_INV_FLUSH_EN
                if (flush_req) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end else
`endif
                if (bus.req_valid) begin
                    tag_d   = pa_tag(bus.req_addr);
                    index_d = pa_index(bus.req_addr);
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (!collide) state_d = ST_CMP;
            end
            ST_CMP: begin
                // The memory port wins: drop this read and re-issue it.
                if (collide) begin
                    state_d = ST_RD;
                end else begin
                    state_d      = ST_IDLE;
                    done_valid_d = 1'b1;
                    done_hit_d   = hit;
                end
            end
`ifdef PU_DC_INV_FLUSH_EN
            ST_FLUSH: begin
                if (!collide) begin
                    if (flush_cnt_q == LAST_INDEX) begin
                        state_d      = ST_IDLE;
                        flush_done_d = 1'b1;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Invalidate-port write strobe; a reset cycle never writes.
    always_comb begin
        wr_en_c   = 1'b0;
        wr_ptag_c = '0;
        if (!rst) begin
            if ((state_q == ST_CMP) && !collide && hit) begin
                wr_en_c   = 1'b1;
                wr_ptag_c = inv_rd_ptag;
            end
`ifdef PU_DC_INV_FLUSH_EN
            if ((state_q == ST_FLUSH) && !collide) wr_en_c = 1'b1;
`endif
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples
        // pre-edge values regardless of block evaluation order.
        if (rst) begin
            state_q      <= ST_IDLE;
            tag_q        <= '0;
            index_q      <= '0;
            done_valid_q <= 1'b0;
            done_hit_q   <= 1'b0;
`ifdef PU_DC_INV_FLUSH_EN
            flush_cnt_q  <= '0;
            flush_done_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            index_q      <= index_d;
            done_valid_q <= done_valid_d;
            done_hit_q   <= done_hit_d;
`ifdef PU_DC_INV_FLUSH_EN
            flush_cnt_q  <= flush_cnt_d;
            flush_done_q <= flush_done_d;
`endif
        end
    end

`ifdef PU_DC_INV_FLUSH_EN
    assign bus.req_ready = (state_q == ST_IDLE) && !flush_req;
    assign flush_done    = flush_done_q;
`else
    assign bus.req_ready = (state_q == ST_IDLE);
`endif
    assign bus.done_valid = done_valid_q;
    assign bus.done_hit   = done_hit_q;
    assign inv_rw_index   = cur_index;
    assign inv_wr_en      = wr_en_c;
    assign inv_wr_ptag    = wr_ptag_c;
    assign inv_wr_valid   = 1'b0;

endmodule

// File: tb/tb_pu_da_inv_ctrl.sv
// Self-checking bench for pu_da_inv_ctrl. Holds a 1-cycle-latency tag/valid
// array, a reference copy of the array contents, and an event scoreboard
// (expected writes and completions per cycle) derived from the rule: an
// invalidate finishes at the first pair of consecutive cycles after
// acceptance free of same-index memory writes; the write (on a hit) lands in
// the second cycle of that pair and done pulses the cycle after.
// Exercises the flush feature when PU_DC_INV_FLUSH_EN is defined.
module tb_pu_da_inv_ctrl;
    import pu_da_inv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pu_da_inv_ctrl_if bus();

    logic               mem_wr_en    = 1'b0;
    logic [INDEX_W-1:0] mem_rw_index = '0;
    logic [INDEX_W-1:0] inv_rw_index;
    logic               inv_wr_en;
    logic [TAG_W-1:0]   inv_wr_ptag;
    logic               inv_wr_valid;
    logic [TAG_W-1:0]   inv_rd_ptag;
    logic               inv_rd_valid;
`ifdef PU_DC_INV_FLUSH_EN
    logic               flush_req;
    logic               flush_done;
`endif

    pu_da_inv_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mem_wr_en    (mem_wr_en),
        .mem_rw_index (mem_rw_index),
        .inv_rw_index (inv_rw_index),
        .inv_wr_en    (inv_wr_en),
        .inv_wr_ptag  (inv_wr_ptag),
        .inv_wr_valid (inv_wr_valid),
        .inv_rd_ptag  (inv_rd_ptag),
        .inv_rd_valid (inv_rd_valid)
`ifdef PU_DC_INV_FLUSH_EN
        ,
        .flush_req    (flush_req),
        .flush_done   (flush_done)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Tag/valid array: address sampled at the edge, data one cycle later.
    logic [TAG_W-1:0] mem_tag   [128];
    logic             mem_valid [128];
    logic             pre_clr = 1'b0;
    logic             pre_en  = 1'b0;
    logic [6:0]       pre_idx = '0;
    logic [19:0]      pre_tag = '0;
    logic             pre_v   = 1'b0;

    always @(posedge clk) begin
        if (pre_clr) begin
            for (int i = 0; i < 128; i++) begin
                mem_tag[i]   <= '0;
                mem_valid[i] <= 1'b0;
            end
        end else if (pre_en) begin
            mem_tag[pre_idx]   <= pre_tag;
            mem_valid[pre_idx] <= pre_v;
        end
        if (inv_wr_en) begin
            mem_tag[inv_rw_index]   <= inv_wr_ptag;
            mem_valid[inv_rw_index] <= inv_wr_valid;
        end
        inv_rd_ptag  <= mem_tag[inv_rw_index];
        inv_rd_valid <= mem_valid[inv_rw_index];
    end

    // Snooped memory-port writes, scheduled by cycle number.
    logic [6:0] mem_sched [int];
    always @(posedge clk) begin
        #1;
        if (mem_sched.exists(cyc)) begin
            mem_wr_en    = 1'b1;
            mem_rw_index = mem_sched[cyc];
        end else begin
            mem_wr_en    = 1'b0;
        end
    end

    // Reference model state.
    logic [19:0] ref_tag   [128];
    logic        ref_valid [128];
    bit          exp_done   [int];
    logic [6:0]  exp_wr_idx [int];
    logic [19:0] exp_wr_tag [int];
    int          busy_from = 0;
    int          busy_to   = 0;
    int          flush_done_at = -1;

    function automatic bit collides(input int c, input logic [6:0] idx);
        return mem_sched.exists(c) && (mem_sched[c] == idx);
    endfunction

    // Per-cycle comparison against the scoreboard.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("req_ready", 32'(bus.req_ready), 32'(!(cyc >= busy_from && cyc < busy_to)));
            check("done_valid", 32'(bus.done_valid), 32'(exp_done.exists(cyc)));
            if (exp_done.exists(cyc) && bus.done_valid)
                check("done_hit", 32'(bus.done_hit), 32'(exp_done[cyc]));
            check("inv_wr_en", 32'(inv_wr_en), 32'(exp_wr_idx.exists(cyc)));
            if (exp_wr_idx.exists(cyc) && inv_wr_en) begin
                check("inv_rw_index", 32'(inv_rw_index), 32'(exp_wr_idx[cyc]));
                check("inv_wr_ptag", 32'(inv_wr_ptag), 32'(exp_wr_tag[cyc]));
                check("inv_wr_valid", 32'(inv_wr_valid), 32'd0);
            end
`ifdef PU_DC_INV_FLUSH_EN
            check("flush_done", 32'(flush_done), 32'(cyc == flush_done_at));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic preload(input logic [6:0] idx, input logic [19:0] tg, input logic v);
        pre_en = 1'b1; pre_idx = idx; pre_tag = tg; pre_v = v;
        ref_tag[idx] = tg; ref_valid[idx] = v;
        step();
        pre_en = 1'b0;
    endtask

    // Issue one request in the current cycle and record its expected effects.
    task automatic send(input logic [31:0] addr, output int done_at);
        int a, t;
        logic [6:0]  idx;
        logic [19:0] tg;
        bit hit;
        a   = cyc;
        idx = addr[11:5];
        tg  = addr[31:12];
        t   = a + 1;
        while (collides(t, idx) || collides(t + 1, idx)) t++;
        hit = ref_valid[idx] && (ref_tag[idx] == tg);
        if (hit) begin
            exp_wr_idx[t + 1] = idx;
            exp_wr_tag[t + 1] = tg;
            ref_valid[idx]    = 1'b0;
        end
        done_at = t + 2;
        exp_done[done_at] = hit;
        busy_from = a + 1;
        busy_to   = done_at;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        step();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, d, d2, bad;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
`ifdef PU_DC_INV_FLUSH_EN
        flush_req = 1'b0;
`endif
        for (int i = 0; i < 128; i++) begin
            ref_tag[i]   = '0;
            ref_valid[i] = 1'b0;
        end
        pre_clr = 1'b1;
        rst     = 1'b1;
        repeat (3) step();
        pre_clr = 1'b0;
        rst     = 1'b0;

        // Reset values.
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_done_valid", 32'(bus.done_valid), 32'd0);
        check("rst_done_hit", 32'(bus.done_hit), 32'd0);
        check("rst_inv_wr_en", 32'(inv_wr_en), 32'd0);
        check("rst_inv_rw_index", 32'(inv_rw_index), 32'd0);
        check("rst_inv_wr_ptag", 32'(inv_wr_ptag), 32'd0);
        check("rst_inv_wr_valid", 32'(inv_wr_valid), 32'd0);
        chk_en = 1'b1;
        step();

        // Hit: write at cycle 2, done_hit at cycle 3.
        preload(7'h33, 20'h12345, 1'b1);
        a = cyc;
        send(32'h1234_5660, d);
        wait_to(a + 2);
        @(negedge clk);
        check("hit_wr_en_c2", 32'(inv_wr_en), 32'd1);
        check("hit_wr_index_c2", 32'(inv_rw_index), 32'h33);
        check("hit_wr_ptag_c2", 32'(inv_wr_ptag), 32'h12345);
        wait_to(a + 3);
        @(negedge clk);
        check("hit_done_c3", 32'(bus.done_valid), 32'd1);
        check("hit_done_hit_c3", 32'(bus.done_hit), 32'd1);

        // Re-request the now-invalid line, accepted in the done cycle.
        send(32'h1234_5660, d);
        wait_to(d);
        @(negedge clk);
        check("rereq_done_hit", 32'(bus.done_hit), 32'd0);
        step();

        // Tag mismatch, then valid=0 with matching tag.
        preload(7'h33, 20'h12346, 1'b1);
        send(32'h1234_5660, d);
        wait_to(d);
        step();
        preload(7'h33, 20'h12345, 1'b0);
        send(32'h1234_5660, d);
        wait_to(d);
        step();

        // Same-index memory writes during RD and during the first CMP.
        preload(7'h33, 20'h12345, 1'b1);
        a = cyc;
        mem_sched[a + 1] = 7'h33;
        mem_sched[a + 3] = 7'h33;
        send(32'h1234_5660, d);
        wait_to(a + 6);
        @(negedge clk);
        check("coll_done_c6", 32'(bus.done_valid), 32'd1);
        check("coll_done_hit_c6", 32'(bus.done_hit), 32'd1);
        step();

        // Different-index memory writes cause no delay.
        preload(7'h33, 20'h12345, 1'b1);
        a = cyc;
        mem_sched[a + 1] = 7'h10;
        mem_sched[a + 2] = 7'h10;
        send(32'h1234_5660, d);
        wait_to(a + 3);
        @(negedge clk);
        check("other_idx_done_c3", 32'(bus.done_valid), 32'd1);
        step();

        // Back-to-back requests to indices 0x00 and 0x7F.
        preload(7'h00, 20'hAAAAA, 1'b1);
        preload(7'h7F, 20'h00001, 1'b1);
        a = cyc;
        send(32'hAAAA_A01F, d);
        wait_to(d);
        send(32'h0000_1FE0, d2);
        wait_to(a + 6);
        @(negedge clk);
        check("b2b_second_done_c6", 32'(bus.done_valid), 32'd1);
        check("b2b_second_hit", 32'(bus.done_hit), 32'd1);
        step();

        // Reset asserted during CMP of a hit.
        preload(7'h33, 20'h12345, 1'b1);
        a = cyc;
        busy_from = a + 1;
        busy_to   = a + 2;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h1234_5660;
        step();
        bus.req_valid = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rst_cmp_wr_en", 32'(inv_wr_en), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("post_rst_done_valid", 32'(bus.done_valid), 32'd0);
        check("post_rst_inv_wr_en", 32'(inv_wr_en), 32'd0);
        check("post_rst_inv_rw_index", 32'(inv_rw_index), 32'd0);
        check("post_rst_inv_wr_ptag", 32'(inv_wr_ptag), 32'd0);
        step();

        // The aborted invalidate left the line valid.
        send(32'h1234_5660, d);
        wait_to(d);
        @(negedge clk);
        check("after_abort_hit", 32'(bus.done_hit), 32'd1);
        step();

`ifdef PU_DC_INV_FLUSH_EN
        // Flush wins over a simultaneous request and clears every line.
        preload(7'h05, 20'h00055, 1'b1);
        a = cyc;
        busy_from = a;
        busy_to   = a + 129;
        flush_done_at = a + 129;
        for (int i = 0; i < 128; i++) begin
            exp_wr_idx[a + 1 + i] = 7'(i);
            exp_wr_tag[a + 1 + i] = '0;
            ref_tag[i]   = '0;
            ref_valid[i] = 1'b0;
        end
        flush_req     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_50A0;
        step();
        flush_req     = 1'b0;
        bus.req_valid = 1'b0;
        wait_to(a + 129);
        send(32'h0000_50A0, d);
        wait_to(d);
        @(negedge clk);
        check("post_flush_done", 32'(bus.done_valid), 32'd1);
        check("post_flush_miss", 32'(bus.done_hit), 32'd0);
        step();
`endif

        // Final array contents must match the reference copy.
        step();
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            if (mem_valid[i] !== ref_valid[i]) bad++;
            else if (mem_valid[i] && (mem_tag[i] !== ref_tag[i])) bad++;
        end
        check("array_vs_model", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
